rf_write_arbiter: RTL

Shares the single register-file write port between two requesters:
- Port A is the pipeline writeback stage. It has priority and no backpressure.
- Port B is a long-latency unit (mult/div, late load). It uses a valid/ready handshake into a 2-entry buffer.

The block drives the registered one-hot write-enable vector for the 64-entry array, produced through the existing 6-to-64 decoder. A starvation counter forces a one-cycle pipeline stall so that port B always drains.

---
 rtl/rf_pkg.sv | 19 +
 rtl/dec6x64.sv | 16 +
 rtl/rf_wr_fifo2.sv | 81 ++++++++
 rtl/rf_write_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter.
//   RF_ADDR_W       : register address width
//   RF_NREG         : number of register entries (2**RF_ADDR_W)
//   RF_DATA_W       : write data width
//   RF_STARVE_LIMIT : cycles port B may wait with a non-empty buffer before a stall
//   arb_state_e     : arbiter FSM encoding
package rf_pkg;

  localparam int RF_ADDR_W       = 6;
  localparam int RF_NREG         = 64;
  localparam int RF_DATA_W       = 32;
  localparam int RF_STARVE_LIMIT = 4;

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dec6x64.sv
// 6-to-64 one-hot decoder with enable.
//   en   : when low the output is all zeros
//   addr : index of the bit to set
//   dec  : one-hot result
module dec6x64 (
  input  logic        en,
  input  logic [5:0]  addr,
  output logic [63:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[addr] = 1'b1;
  end

endmodule

// File: rtl/rf_wr_fifo2.sv
// Two-entry write buffer for the long-latency port.
// Slot 0 is always the head; slot 1 is only valid when slot 0 is, so when the
// head is removed (pop or invalidate) the second entry slides forward.
//   clk, reset         : clock, asynchronous active-high reset (clears valid bits)
//   push, push_addr/data: append an entry (caller guarantees occ < 2)
//   pop                : remove the head
//   inv_en, inv_addr   : drop every valid entry whose address equals inv_addr
//   head_vld/addr/data : current head entry
//   occ                : number of valid entries (0..2)
module rf_wr_fifo2
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr,
  output logic              head_vld,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occ
);

  logic [1:0]        vld_q, vld_d, keep;
  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_d [2];
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      keep[i] = vld_q[i] && !(inv_en && (addr_q[i] == inv_addr));
    end
    keep[0] = keep[0] && !pop;

    vld_d  = keep;
    addr_d = addr_q;
    data_d = data_q;

    // Head gone but tail survives: tail becomes the new head.
    if (!keep[0] && keep[1]) begin
      addr_d[0] = addr_q[1];
      data_d[0] = data_q[1];
      vld_d     = 2'b01;
    end

    if (push) begin
      if (!vld_d[0]) begin
        addr_d[0] = push_addr;
        data_d[0] = push_data;
        vld_d[0]  = 1'b1;
      end else if (!vld_d[1]) begin
        addr_d[1] = push_addr;
        data_d[1] = push_data;
        vld_d[1]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= 2'b00;
    else       vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign head_vld  = vld_q[0];
  assign head_addr = addr_q[0];
  assign head_data = data_q[0];
  assign occ       = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the writeback stage
// (port A, priority, no backpressure) and a long-latency unit (port B,
// valid/ready into a 2-entry buffer). A starvation counter forces a one-cycle
// pipeline stall so buffered B writes always drain.
//   clk, reset       : clock, asynchronous active-high reset
//   a_valid/addr/data: writeback request
//   b_valid/addr/data: long-latency request, b_ready = buffer not full
//   rf_we            : registered one-hot write enable (never bit 0)
//   rf_waddr/wdata   : registered address/data of the last granted write
//   stall_pipe       : registered; writeback must hold a_valid low while high
//   err_collide      : sticky; a_valid seen while stall_pipe was high
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int NREG         = RF_NREG,
  parameter int DATA_W       = RF_DATA_W,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [NREG-1:0]   rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_pipe,
  output logic              err_collide
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(STARVE_LIMIT - 1);

  logic              head_vld;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        occ;
  logic              push, b_grant, starve;

  logic              win_vld_p0, we_en_p0;
  logic [ADDR_W-1:0] win_addr_p0;
  logic [DATA_W-1:0] win_data_p0;
  logic [63:0]       dec_p0;

  logic [NREG-1:0]   we_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              err_q, collide_set;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // ---- p0: buffer, grant selection and decode ----
  assign b_ready = (occ != 2'd2);
  assign push    = b_valid && b_ready;
  assign b_grant = !a_valid && head_vld;
  assign starve  = head_vld && !b_grant;

  rf_wr_fifo2 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (b_addr),
    .push_data (b_data),
    .pop       (b_grant),
    .inv_en    (a_valid),   // A is program-later: its write kills older B writes to the same reg
    .inv_addr  (a_addr),
    .head_vld  (head_vld),
    .head_addr (head_addr),
    .head_data (head_data),
    .occ       (occ)
  );

  always_comb begin
    win_vld_p0  = a_valid || b_grant;
    win_addr_p0 = a_valid ? a_addr : head_addr;
    win_data_p0 = a_valid ? a_data : head_data;
    // $zero is never written, but the grant still consumes the request.
    we_en_p0    = win_vld_p0 && (win_addr_p0 != '0);
  end

  dec6x64 u_dec (
    .en   (we_en_p0),
    .addr (win_addr_p0[5:0]),
    .dec  (dec_p0)
  );

  always_comb begin
    cnt_d = '0;
    if (starve) cnt_d = (cnt_q < CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= NORMAL;
    else       state_q <= state_d;
  end

  // FSM next state. The ">=" keeps a saturated counter able to re-trigger a
  // stall if the previous one was lost to a collision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (starve && (cnt_q >= CNT_TRIG)) state_d = STALL;
      STALL:   state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // FSM outputs
  always_comb begin
    stall_pipe  = (state_q == STALL);
    collide_set = (state_q == STALL) && a_valid;
  end

  // ---- p1: registered write port ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_p1    <= '0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      err_q    <= 1'b0;
    end else begin
      we_p1 <= dec_p0[NREG-1:0];
      if (win_vld_p0) begin
        waddr_p1 <= win_addr_p0;
        wdata_p1 <= win_data_p0;
      end
      if (collide_set) err_q <= 1'b1;
    end
  end

  assign rf_we       = we_p1;
  assign rf_waddr    = waddr_p1;
  assign rf_wdata    = wdata_p1;
  assign err_collide = err_q;

endmodule
